relu_maxpool: RTL

- Stage directly downstream of the per-window MAC unit.
- Consumes the serial stream of convolution results (one value per valid pulse, raster order over the conv output map).
- Applies ReLU, then 2x2 max-pooling with stride 2, using a single half-width line buffer.
- Emits one pooled value per completed 2x2 window, plus a frame-done pulse. Output feeds the next layer or the output buffer.

---
 rtl/relu_maxpool.sv | 124 ++++++++++++
 1 files changed

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 / stride-2 max pooling over a raster-ordered stream of
// convolution results. A half-width line buffer keeps the even-row horizontal
// maxima until the odd row completes each window.
module relu_maxpool #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIGN  = 1,
  parameter int unsigned OUT_W = 24,
  parameter int unsigned OUT_H = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] conv_result,
  input  logic             conv_result_valid,
  output logic [WIDTH-1:0] pool_out,
  output logic             pool_valid,
  output logic             frame_done
);

  localparam int unsigned ColW       = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned RowW       = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned LbDepthRaw = OUT_W / 2;
  localparam int unsigned LbDepth    = (LbDepthRaw > 0) ? LbDepthRaw : 1;
  localparam int unsigned LbIdxW     = (LbDepth > 1) ? $clog2(LbDepth) : 1;

  localparam logic [ColW-1:0] ColLast   = ColW'(OUT_W - 1);
  localparam logic [RowW-1:0] RowLast   = RowW'(OUT_H - 1);
  // Columns/rows at or beyond these bounds belong to no complete window.
  localparam logic [ColW:0]   ColUseEnd = (ColW + 1)'((OUT_W / 2) * 2);
  localparam logic [RowW:0]   RowUseEnd = (RowW + 1)'((OUT_H / 2) * 2);

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [WIDTH-1:0]  hreg_q, hreg_d;
  logic [WIDTH-1:0]  pool_out_q, pool_out_d;
  logic              pool_valid_q, pool_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [WIDTH-1:0]  lb_q [LbDepth];

  logic [WIDTH-1:0]  relu_val;
  logic [WIDTH-1:0]  hmax;
  logic [WIDTH-1:0]  lb_rd;
  logic [WIDTH-1:0]  pmax;
  logic [LbIdxW-1:0] lb_idx;
  logic              in_window;
  logic              lb_we;

  // ReLU and the unsigned max operators feeding the pooling registers.
  always_comb begin
    relu_val = conv_result;
    if ((SIGN != 0) && conv_result[WIDTH-1]) begin
      relu_val = '0;
    end
    hmax      = (hreg_q > relu_val) ? hreg_q : relu_val;
    lb_idx    = LbIdxW'(col_q >> 1);
    lb_rd     = lb_q[lb_idx];
    pmax      = (lb_rd > hmax) ? lb_rd : hmax;
    in_window = ({1'b0, col_q} < ColUseEnd) && ({1'b0, row_q} < RowUseEnd);
  end

  // Next-state: raster counters, horizontal max, line buffer write and outputs.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hreg_d       = hreg_q;
    pool_out_d   = pool_out_q;
    pool_valid_d = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    if (conv_result_valid) begin
      if (col_q == ColLast) begin
        col_d = '0;
        if (row_q == RowLast) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RowW'(1);
        end
      end else begin
        col_d = col_q + ColW'(1);
      end
      if (in_window) begin
        if (!col_q[0]) begin
          hreg_d = relu_val;
        end else if (!row_q[0]) begin
          lb_we = 1'b1;
        end else begin
          pool_out_d   = pmax;
          pool_valid_d = 1'b1;
        end
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hreg_q       <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hreg_q       <= hreg_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer; every entry is written on the even row before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= hmax;
    end
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign frame_done = frame_done_q;

endmodule
